morse_keyer: RTL and testbench

Converts a stream of 3-bit Morse symbol codes (WAIT/DIT/DAH/GAP/SPACE) into an on/off keyed `signal` timed in units of `bigclk` cycles. It is the transmit-side counterpart of the dit/dah decoder: `signal` uses the same framing (1-unit dit, 3-unit dah, 1-unit intra-letter gap, 3-unit letter gap, 7-unit word gap), so a decoder sampling at the same unit rate recovers the original symbols. Symbols enter through a valid/ready handshake into a small FIFO so an upstream character-to-symbol encoder can run ahead of transmission.

---
 rtl/morse_keyer_if.sv | 19 +
 rtl/morse_keyer.sv | 135 +++++++++++++
 tb/tb_morse_keyer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_keyer_if.sv
// morse_keyer_if: symbol handshake into the keyer FIFO.
// The encoder side is master; the keyer answers with ready.
interface morse_keyer_if;
   logic [2:0] sym_in;
   logic       sym_valid;
   logic       sym_ready;

   modport master (
      output sym_in,
      output sym_valid,
      input  sym_ready
   );

   modport slave (
      input  sym_in,
      input  sym_valid,
      output sym_ready
   );
endinterface

// File: rtl/morse_keyer.sv
// morse_keyer: symbol FIFO feeding a Morse element timer.
// signal is a pure decode of the state register.
module morse_keyer #(
   parameter int UNIT  = 1,
   parameter int DEPTH = 4
) (
   input  logic         bigclk,
   input  logic         reset_n,
   morse_keyer_if.slave sym,
   output logic         signal,
   output logic         busy,
   output logic         sym_err
);
   localparam int CW = $clog2(6*UNIT+1);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam logic [2:0] WAIT  = 3'd0;
   localparam logic [2:0] DIT   = 3'd1;
   localparam logic [2:0] DAH   = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] SPACE = 3'd4;

   localparam logic [CW-1:0] C0  = '0;
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] T1  = CW'(UNIT);
   localparam logic [CW-1:0] T2  = CW'(2*UNIT);
   localparam logic [CW-1:0] T3  = CW'(3*UNIT);
   localparam logic [CW-1:0] T6  = CW'(6*UNIT);

   typedef enum logic [1:0] {IDLE, MARK, SPC} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          err_n;
   logic [2:0]    mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic          full, empty, push, pop;
   logic [2:0]    head;

   // extra pointer bit separates full from empty
   assign empty = wptr == rptr;
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

   assign sym.sym_ready = !full;
   assign push = sym.sym_valid && !full;
   assign head = mem[rptr[AW-1:0]];
   assign pop  = !empty &&
                 (state == IDLE || (state == SPC && cnt == ONE));

   assign signal = state == MARK;
   assign busy   = state != IDLE || !empty;

   always_ff @(posedge bigclk or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
      end
   end

   always_ff @(posedge bigclk) begin
      if (push) mem[wptr[AW-1:0]] <= sym.sym_in;
   end

   always_ff @(posedge bigclk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= C0;
         sym_err <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         sym_err <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_n   = 1'b0;
      unique case (state)
         MARK: begin
            if (cnt == ONE) begin
               state_n = SPC;
               cnt_n   = T1;
            end else begin
               cnt_n = cnt - ONE;
            end
         end
         SPC: begin
            if (cnt == ONE) begin
               state_n = IDLE;
               cnt_n   = C0;
            end else begin
               cnt_n = cnt - ONE;
            end
         end
         default: ;
      endcase
      // a pop overrides the timer so elements run back to back
      if (pop) begin
         unique case (1'b1)
            head == DIT: begin
               state_n = MARK;
               cnt_n   = T1;
            end
            head == DAH: begin
               state_n = MARK;
               cnt_n   = T3;
            end
            head == GAP: begin
               state_n = SPC;
               cnt_n   = T2;
            end
            head == SPACE: begin
               state_n = SPC;
               cnt_n   = T6;
            end
            head == WAIT: begin
               state_n = IDLE;
               cnt_n   = C0;
            end
            default: begin
               state_n = IDLE;
               cnt_n   = C0;
               err_n   = 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: directed vectors against a queue-based timing model.
// Two instances cover UNIT=1 and UNIT=2.
module tb_morse_keyer;
   localparam int DEPTH = 4;
   localparam logic [2:0] WT = 3'd0;
   localparam logic [2:0] DT = 3'd1;
   localparam logic [2:0] DH = 3'd2;
   localparam logic [2:0] GP = 3'd3;
   localparam logic [2:0] SP = 3'd4;

   logic bigclk  = 1'b0;
   logic reset_n = 1'b0;
   logic s1, b1, e1, s2, b2, e2;
   int   checks = 0;
   int   errors = 0;
   int   hic [2] = '{0, 0};
   int   erc [2] = '{0, 0};

   logic [2:0] mq [2][$];
   bit         mw [2][$];
   logic       merr [2] = '{1'b0, 1'b0};

   always #5 bigclk = ~bigclk;

   morse_keyer_if if1 ();
   morse_keyer_if if2 ();

   morse_keyer #(.UNIT(1), .DEPTH(DEPTH)) u1 (
      .bigclk(bigclk), .reset_n(reset_n), .sym(if1),
      .signal(s1), .busy(b1), .sym_err(e1)
   );

   morse_keyer #(.UNIT(2), .DEPTH(DEPTH)) u2 (
      .bigclk(bigclk), .reset_n(reset_n), .sym(if2),
      .signal(s2), .busy(b2), .sym_err(e2)
   );

   function automatic logic dsig(int d);
      return (d == 0) ? s1 : s2;
   endfunction
   function automatic logic dbusy(int d);
      return (d == 0) ? b1 : b2;
   endfunction
   function automatic logic derr(int d);
      return (d == 0) ? e1 : e2;
   endfunction
   function automatic logic drdy(int d);
      return (d == 0) ? if1.sym_ready : if2.sym_ready;
   endfunction

   task automatic chk(string nm, int d, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual %b required %b at %0t",
                  nm, d, act, exp, $time);
      end
   endtask

   task automatic chkv(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d (0x%0h) required %0d (0x%0h)",
                  nm, act, act, exp, exp);
      end
   endtask

   // model: each popped symbol expands into its mark/space cycles
   task automatic emit(int d, bit b, int n);
      for (int i = 0; i < n; i++) mw[d].push_back(b);
   endtask

   task automatic step(int d, logic v, logic [2:0] s);
      int u;
      logic acc, pp;
      logic [2:0] h;
      u   = d + 1;
      acc = v && (mq[d].size() < DEPTH);
      pp  = (mq[d].size() > 0) && (mw[d].size() <= 1);
      merr[d] = 1'b0;
      if (mw[d].size() > 0) void'(mw[d].pop_front());
      if (pp) begin
         h = mq[d].pop_front();
         case (h)
            DT: begin emit(d, 1'b1, u); emit(d, 1'b0, u); end
            DH: begin emit(d, 1'b1, 3*u); emit(d, 1'b0, u); end
            GP: emit(d, 1'b0, 2*u);
            SP: emit(d, 1'b0, 6*u);
            WT: ;
            default: merr[d] = 1'b1;
         endcase
      end
      if (acc) mq[d].push_back(s);
   endtask

   always @(posedge bigclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            mw[d].delete();
            merr[d] = 1'b0;
         end
      end else begin
         step(0, if1.sym_valid, if1.sym_in);
         step(1, if2.sym_valid, if2.sym_in);
      end
   end

   always @(negedge bigclk) begin
      for (int d = 0; d < 2; d++) begin
         logic ex;
         ex = (mw[d].size() > 0) ? mw[d][0] : 1'b0;
         chk("signal", d, dsig(d), ex);
         chk("busy", d, dbusy(d),
             (mw[d].size() > 0) || (mq[d].size() > 0));
         chk("sym_ready", d, drdy(d), mq[d].size() < DEPTH);
         chk("sym_err", d, derr(d), merr[d]);
         if (dsig(d) === 1'b1) hic[d]++;
         if (derr(d) === 1'b1) erc[d]++;
      end
   end

   task automatic drive(int d, logic v, logic [2:0] s);
      if (d == 0) begin
         if1.sym_valid = v;
         if1.sym_in    = s;
      end else begin
         if2.sym_valid = v;
         if2.sym_in    = s;
      end
   endtask

   task automatic push(int d, logic [2:0] s, output int waits);
      waits = 0;
      drive(d, 1'b1, s);
      while (!drdy(d) && waits < 100) begin
         @(negedge bigclk);
         waits++;
      end
      chk("push_ready", d, drdy(d), 1'b1);
      @(negedge bigclk);
      drive(d, 1'b0, 3'd0);
   endtask

   task automatic capture(int d, int n,
                          output logic [31:0] ts,
                          output logic [31:0] bt);
      ts = '0;
      bt = '0;
      for (int i = 0; i < n; i++) begin
         ts = {ts[30:0], dsig(d)};
         bt = {bt[30:0], dbusy(d)};
         @(negedge bigclk);
      end
   endtask

   task automatic wait_idle(int d);
      int n;
      n = 0;
      while (dbusy(d) && n < 300) begin
         @(negedge bigclk);
         n++;
      end
      chk("idle_timeout", d, dbusy(d), 1'b0);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ts, bt;
      int w;
      int ws [6];
      drive(0, 1'b0, 3'd0);
      drive(1, 1'b0, 3'd0);
      repeat (2) @(negedge bigclk);
      chk("rst_signal", 0, s1, 1'b0);
      chk("rst_ready", 0, if1.sym_ready, 1'b1);
      chk("rst_busy", 0, b1, 1'b0);
      chk("rst_err", 0, e1, 1'b0);
      reset_n = 1'b1;
      @(negedge bigclk);

      push(0, DT, w);
      capture(0, 4, ts, bt);
      chkv("dit_signal", int'(ts[3:0]), 'b0100);
      chkv("dit_busy", int'(bt[3:0]), 'b1110);
      wait_idle(0);

      push(0, DT, w);
      push(0, DH, w);
      push(0, GP, w);
      capture(0, 8, ts, bt);
      chkv("letter_a", int'(ts[7:0]), 'b01110000);
      wait_idle(0);

      push(1, DT, w);
      push(1, SP, w);
      push(1, DT, w);
      capture(1, 20, ts, bt);
      chkv("unit2_word", int'(ts[19:0]), 'b10000000000000011000);
      wait_idle(1);

      hic[0] = 0;
      for (int i = 0; i < 6; i++) begin
         push(0, DH, w);
         ws[i] = w;
      end
      chkv("bp_wait5", ws[4], 0);
      chkv("bp_wait6", ws[5], 1);
      wait_idle(0);
      chkv("bp_highs", hic[0], 18);

      erc[0] = 0;
      push(0, WT, w);
      push(0, 3'd6, w);
      push(0, DT, w);
      chk("err_pulse", 0, e1, 1'b1);
      capture(0, 4, ts, bt);
      chkv("wait_dit", int'(ts[3:0]), 'b0100);
      wait_idle(0);
      chkv("err_count", erc[0], 1);

      push(0, GP, w);
      for (int i = 0; i < 4; i++) push(0, DH, w);
      chk("mark_pre_rst", 0, s1, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_async_sig", 0, s1, 1'b0);
      chk("rst_async_busy", 0, b1, 1'b0);
      chk("rst_async_rdy", 0, if1.sym_ready, 1'b1);
      repeat (2) @(negedge bigclk);
      reset_n = 1'b1;
      #1;
      hic[0] = 0;
      repeat (15) @(negedge bigclk);
      #1;
      chkv("rst_quiet", hic[0], 0);
      push(0, DT, w);
      capture(0, 4, ts, bt);
      chkv("post_rst_dit", int'(ts[3:0]), 'b0100);
      wait_idle(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
